// File: rtl/image_capture_ctrl_pkg.sv
// Shared constants, state type and pixel helper for the image capture front end.
package image_capture_ctrl_pkg;

   localparam int unsigned IMG_W   = 32;
   localparam int unsigned IMG_PIX = IMG_W * IMG_W;
   localparam int unsigned IDX_W   = $clog2(IMG_PIX);

   localparam logic [3:0] TIMEOUT_DIGIT = 4'hF;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_KICK = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } cap_state_t;

   typedef logic [IDX_W-1:0] pix_idx_t;

   function automatic logic thresh_bit(input logic [7:0] pix, input logic [7:0] thresh);
      return (pix >= thresh);
   endfunction

endpackage

// File: rtl/image_capture_ctrl_bit_buffer.sv
// 1024-bit bitmap store: indexed single-bit write, whole-buffer clear, write freeze.
module image_bit_buffer
   import image_capture_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               iRst_n,
   input  logic               i_clr,
   input  logic               i_freeze,
   input  logic               i_wr_en,
   input  pix_idx_t           i_wr_idx,
   input  logic               i_wr_bit,
   output logic [IMG_PIX-1:0] o_bits
);

   logic [IMG_PIX-1:0] r_bits;

   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         r_bits <= '0;
      end else if (i_clr) begin
         r_bits <= '0;
      end else if (i_wr_en && !i_freeze) begin
         r_bits[i_wr_idx] <= i_wr_bit;
      end
   end

   assign o_bits = r_bits;

endmodule

// File: rtl/image_capture_ctrl.sv
// Thresholds a raster pixel stream into a 32x32 bitmap, runs the TPU on it and
// hands the classified digit to the consumer with a valid/ack handshake.
module image_capture_ctrl
   import image_capture_ctrl_pkg::*;
#(
   parameter logic [7:0]  THRESH  = 8'd128,
   parameter logic [19:0] TIMEOUT = 20'd1000000
) (
   input  logic               clk,
   input  logic               iRst_n,
   input  logic [7:0]         pix_data,
   input  logic               pix_valid,
   input  logic               pix_sof,
   output logic               pix_ready,
   output logic [IMG_PIX-1:0] input_image,
   output logic               tpu_ena,
   output logic               tpu_rst_n,
   input  logic [3:0]         tpu_num,
   input  logic               tpu_overflow,
   input  logic               tpu_done,
   output logic               result_valid,
   input  logic               result_ack,
   output logic [3:0]         digit,
   output logic               overflow,
   output logic               timeout,
   output logic               resync_err
);

   cap_state_t  r_state,   w_state_nxt;
   pix_idx_t    r_cnt,     w_cnt_nxt;
   logic [19:0] r_wdog,    w_wdog_nxt;
   logic [3:0]  r_digit,   w_digit_nxt;
   logic        r_ovf,     w_ovf_nxt;
   logic        r_timeout, w_timeout_nxt;
   logic        r_resync,  w_resync_nxt;

   logic        w_accept;
   pix_idx_t    w_wr_idx;
   logic        w_wr_bit;
   logic        w_clr;
   logic        w_freeze;
   logic        w_tpu_done;

   assign w_accept   = pix_valid && (r_state == ST_FILL);
   // A start-of-frame pixel always lands at index 0, restarting the raster.
   assign w_wr_idx   = pix_sof ? '0 : r_cnt;
   assign w_wr_bit   = thresh_bit(pix_data, THRESH);
   assign w_tpu_done = (tpu_done === 1'b1);
   assign w_clr      = (r_state == ST_DONE) && result_ack;
   assign w_freeze   = (r_state != ST_FILL);

   image_bit_buffer u_buf (
      .clk      (clk),
      .iRst_n   (iRst_n),
      .i_clr    (w_clr),
      .i_freeze (w_freeze),
      .i_wr_en  (w_accept),
      .i_wr_idx (w_wr_idx),
      .i_wr_bit (w_wr_bit),
      .o_bits   (input_image)
   );

   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         r_state   <= ST_FILL;
         r_cnt     <= '0;
         r_wdog    <= '0;
         r_digit   <= '0;
         r_ovf     <= 1'b0;
         r_timeout <= 1'b0;
         r_resync  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_wdog    <= w_wdog_nxt;
         r_digit   <= w_digit_nxt;
         r_ovf     <= w_ovf_nxt;
         r_timeout <= w_timeout_nxt;
         r_resync  <= w_resync_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_wdog_nxt    = r_wdog;
      w_digit_nxt   = r_digit;
      w_ovf_nxt     = r_ovf;
      w_timeout_nxt = r_timeout;
      w_resync_nxt  = r_resync;
      pix_ready     = 1'b0;
      tpu_ena       = 1'b0;
      tpu_rst_n     = 1'b1;
      result_valid  = 1'b0;

      case (r_state)
         ST_FILL: begin
            pix_ready = 1'b1;
            if (w_accept) begin
               w_cnt_nxt = w_wr_idx + 1'b1;
               if (pix_sof && (r_cnt != '0)) begin
                  w_resync_nxt = 1'b1;
               end
               if (w_wr_idx == pix_idx_t'(IMG_PIX - 1)) begin
                  w_state_nxt = ST_KICK;
               end
            end
         end
         ST_KICK: begin
            tpu_ena     = 1'b1;
            tpu_rst_n   = 1'b0;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            tpu_ena    = 1'b1;
            w_wdog_nxt = r_wdog + 20'd1;
            // A done flag arriving on the timeout cycle still counts as done.
            if (w_tpu_done) begin
               w_digit_nxt = tpu_num;
               w_ovf_nxt   = tpu_overflow;
               w_state_nxt = ST_DONE;
            end else if (r_wdog == TIMEOUT - 20'd1) begin
               w_digit_nxt   = TIMEOUT_DIGIT;
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ST_DONE;
            end
         end
         ST_DONE: begin
            tpu_ena      = 1'b1;
            result_valid = 1'b1;
            if (result_ack) begin
               w_timeout_nxt = 1'b0;
               w_wdog_nxt    = '0;
               w_state_nxt   = ST_FILL;
            end
         end
         default: begin
            w_state_nxt = ST_FILL;
         end
      endcase
   end

   assign digit      = r_digit;
   assign overflow   = r_ovf;
   assign timeout    = r_timeout;
   assign resync_err = r_resync;

endmodule
